// File: rtl/oam_dma.sv
// OAM DMA engine: copies LENGTH bytes from page XX into OAM at 0xFE00.
// Read/write bus master with held request and one-cycle acknowledge.
module oam_dma #(
    parameter int                   ADDR_SIZE    = 16,
    parameter int                   DATA_SIZE    = 8,
    parameter logic [ADDR_SIZE-1:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [ADDR_SIZE-1:0] OAM_BASE     = 16'hFE00,
    parameter int                   LENGTH       = 160,
    parameter int                   START_DELAY  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [DATA_SIZE-1:0] cpu_wdata,
    input  logic                 cpu_we,
    output logic [DATA_SIZE-1:0] cpu_rdata,
    output logic                 cpu_hit,
    output logic                 m_req,
    output logic                 m_we,
    output logic [ADDR_SIZE-1:0] m_addr,
    output logic [DATA_SIZE-1:0] m_wdata,
    input  logic [DATA_SIZE-1:0] m_rdata,
    input  logic                 m_ack,
    output logic                 busy,
    output logic                 oam_lock,
    output logic                 done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DELAY = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [7:0] DELAY_INIT  = 8'(START_DELAY);
    localparam logic [2:0] START_STATE = (START_DELAY == 0) ? S_RD : S_DELAY;
    localparam logic [7:0] LAST_IDX    = 8'(LENGTH - 1);

    logic [2:0]           state_q, state_d;
    logic [DATA_SIZE-1:0] dma_reg_q, dma_reg_d;
    logic [7:0]           byte_idx_q, byte_idx_d;
    logic [7:0]           delay_q, delay_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 m_req_q, m_req_d;
    logic                 m_we_q, m_we_d;
    logic [ADDR_SIZE-1:0] m_addr_q, m_addr_d;
    logic [DATA_SIZE-1:0] m_wdata_q, m_wdata_d;

    logic                 cpu_start;
    logic [7:0]           src_hi;
    logic [ADDR_SIZE-1:0] src_addr;
    logic [ADDR_SIZE-1:0] dst_addr;

    assign cpu_hit   = (cpu_addr == DMA_REG_ADDR);
    assign cpu_rdata = cpu_hit ? dma_reg_q : '0;
    assign cpu_start = cpu_we && cpu_hit;

    // Pages 0xE0..0xFF mirror work RAM 0x20 pages lower
    assign src_hi   = (dma_reg_q[7:0] < 8'hE0) ? dma_reg_q[7:0]
                                               : dma_reg_q[7:0] - 8'h20;
    assign src_addr = ADDR_SIZE'({src_hi, byte_idx_q});
    assign dst_addr = OAM_BASE + ADDR_SIZE'(byte_idx_q);

    always_comb begin
        state_d    = state_q;
        dma_reg_d  = dma_reg_q;
        byte_idx_d = byte_idx_q;
        delay_d    = delay_q;
        data_d     = data_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if (cpu_start) begin
            // A register write always (re)starts, dropping any open request
            dma_reg_d  = cpu_wdata;
            byte_idx_d = 8'd0;
            delay_d    = DELAY_INIT;
            m_req_d    = 1'b0;
            state_d    = START_STATE;
        end else begin
            case (state_q)
                S_DELAY: begin
                    if (delay_q <= 8'd1) begin
                        state_d = S_RD;
                    end else begin
                        delay_d = delay_q - 8'd1;
                    end
                end
                S_RD: begin
                    if (!m_req_q) begin
                        m_req_d  = 1'b1;
                        m_we_d   = 1'b0;
                        m_addr_d = src_addr;
                    end else if (m_ack) begin
                        data_d  = m_rdata;
                        m_req_d = 1'b0;
                        state_d = S_WR;
                    end
                end
                S_WR: begin
                    if (!m_req_q) begin
                        m_req_d   = 1'b1;
                        m_we_d    = 1'b1;
                        m_addr_d  = dst_addr;
                        m_wdata_d = data_q;
                    end else if (m_ack) begin
                        m_req_d = 1'b0;
                        if (byte_idx_q == LAST_IDX) begin
                            state_d = S_FIN;
                        end else begin
                            byte_idx_d = byte_idx_q + 8'd1;
                            state_d    = S_RD;
                        end
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dma_reg_q  <= '0;
            byte_idx_q <= 8'd0;
            delay_q    <= 8'd0;
            data_q     <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            dma_reg_q  <= dma_reg_d;
            byte_idx_q <= byte_idx_d;
            delay_q    <= delay_d;
            data_q     <= data_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign busy     = (state_q != S_IDLE);
    assign oam_lock = busy;
    assign done     = (state_q == S_FIN);

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: random-latency bus responder with a memory model,
// transfers checked against the expected page copy.
module tb_oam_dma;

    localparam int LEN = 160;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        cpu_hit;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata = 8'h00;
    logic        m_ack = 1'b0;
    logic        busy;
    logic        oam_lock;
    logic        done;

    oam_dma dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_we   (cpu_we),
        .cpu_rdata(cpu_rdata),
        .cpu_hit  (cpu_hit),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .busy     (busy),
        .oam_lock (oam_lock),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_q [$];
    logic [15:0] wa_q [$];
    logic [7:0]  wd_q [$];
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int lat_max = 0;
    int wait_cnt = 0;
    bit resp_en = 1'b1;
    bit force_ack = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_we = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    logic [7:0]  prev_wdata = 8'h0;

    // Bus slave: acks after a random wait, reads/writes the memory model
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (m_req && prev_req && !prev_ack) begin
            checks++;
            if ({m_we, m_addr, m_wdata} !== {prev_we, prev_addr, prev_wdata}) begin
                errors++;
                $display("FAIL req_stable: got %h expected %h",
                         {m_we, m_addr, m_wdata}, {prev_we, prev_addr, prev_wdata});
            end
        end
        if (prev_ack) begin
            checks++;
            if (m_req !== 1'b0) begin
                errors++;
                $display("FAIL req_gap: got m_req=%b expected 0", m_req);
            end
        end
        m_ack   = force_ack;
        m_rdata = 8'($urandom);
        if (resp_en && m_req && !reset) begin
            if (wait_cnt == 0) begin
                m_ack = 1'b1;
                if (m_we) begin
                    mem[m_addr] = m_wdata;
                    wa_q.push_back(m_addr);
                    wd_q.push_back(m_wdata);
                end else begin
                    m_rdata = mem[m_addr];
                    rd_q.push_back(m_addr);
                end
                wait_cnt = int'($urandom_range(lat_max));
            end else begin
                wait_cnt--;
            end
        end
        prev_req   = m_req;
        prev_ack   = m_ack;
        prev_we    = m_we;
        prev_addr  = m_addr;
        prev_wdata = m_wdata;
    end

    function automatic logic [7:0] src_page(input logic [7:0] v);
        return (v < 8'hE0) ? v : v - 8'h20;
    endfunction

    function automatic void fill_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    endfunction

    function automatic void clear_logs();
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
    endfunction

    // Number of bus operations that differ from an in-order page copy
    function automatic int log_bad(input logic [7:0] v);
        logic [7:0] hi;
        int bad;
        hi  = src_page(v);
        bad = 0;
        if (rd_q.size() != LEN || wa_q.size() != LEN) return 1000;
        for (int i = 0; i < LEN; i++) begin
            if (rd_q[i] !== {hi, 8'(i)}) bad++;
            if (wa_q[i] !== 16'hFE00 + 16'(i)) bad++;
            if (wd_q[i] !== mem[{hi, 8'(i)}]) bad++;
        end
        return bad;
    endfunction

    function automatic int oam_bad(input logic [7:0] v);
        logic [7:0] hi;
        int bad;
        hi  = src_page(v);
        bad = 0;
        for (int i = 0; i < LEN; i++) begin
            if (mem[16'hFE00 + 16'(i)] !== mem[{hi, 8'(i)}]) bad++;
        end
        return bad;
    endfunction

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        @(negedge clk);
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        cpu_addr = 16'hFF46;
        #1;
        checks++;
        if ({m_req, busy, oam_lock, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0000",
                     {m_req, busy, oam_lock, done});
        end
        checks++;
        if (m_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0000", m_addr);
        end
        checks++;
        if ({cpu_hit, cpu_rdata} !== 9'h100) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 100", {cpu_hit, cpu_rdata});
        end
        cpu_write(16'hFF47, 8'h12);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL other_addr_busy: got %b expected 0", busy);
        end
        cpu_addr = 16'hFF47;
        #1;
        checks++;
        if ({cpu_hit, cpu_rdata} !== 9'h000) begin
            errors++;
            $display("FAIL miss_rdata: got %h expected 000", {cpu_hit, cpu_rdata});
        end
        cpu_addr = 16'hFF46;
        #1;
        checks++;
        if (cpu_rdata !== 8'h00) begin
            errors++;
            $display("FAIL other_addr_reg: got %h expected 00", cpu_rdata);
        end
        cpu_addr = 16'h0000;
    endtask

    task automatic test_basic();
        bit ok;
        int bad;
        fill_mem();
        for (int i = 0; i < LEN; i++) begin
            mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
            mem[16'hFE00 + 16'(i)] = ~(8'(i) ^ 8'h5A);
        end
        clear_logs();
        lat_max = 0;
        cpu_write(16'hFF46, 8'hC0);
        checks++;
        if ({busy, oam_lock} !== 2'b11) begin
            errors++;
            $display("FAIL basic_busy: got %b expected 11", {busy, oam_lock});
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: got busy=%b expected 0", busy);
        end
        bad = log_bad(8'hC0);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL basic_bus: got %0d bad ops expected 0", bad);
        end
        bad = 0;
        for (int i = 0; i < LEN; i++)
            if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL basic_oam: got %0d bad bytes expected 0", bad);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL basic_done: got %0d pulses expected 1", done_cnt);
        end
        cpu_addr = 16'hFF46;
        #1;
        checks++;
        if ({busy, cpu_rdata} !== 9'h0C0) begin
            errors++;
            $display("FAIL basic_after: got %h expected 0c0", {busy, cpu_rdata});
        end
        cpu_addr = 16'h0000;
    endtask

    task automatic test_echo();
        bit ok;
        int bad;
        fill_mem();
        clear_logs();
        lat_max = 2;
        cpu_write(16'hFF46, 8'hFE);
        wait_idle(ok);
        checks++;
        if (!ok || rd_q.size() == 0) begin
            errors++;
            $display("FAIL echo_timeout: got %0d reads expected %0d", rd_q.size(), LEN);
        end else begin
            checks++;
            if ({rd_q[0], rd_q[rd_q.size()-1]} !== 32'hDE00_DE9F) begin
                errors++;
                $display("FAIL echo_addr: got %h %h expected de00 de9f",
                         rd_q[0], rd_q[rd_q.size()-1]);
            end
        end
        bad = log_bad(8'hFE);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL echo_bus: got %0d bad ops expected 0", bad);
        end
    endtask

    task automatic test_latency();
        bit ok;
        int bad;
        logic [7:0] v;
        for (int n = 0; n < 3; n++) begin
            v = 8'($urandom_range(255));
            fill_mem();
            clear_logs();
            lat_max = 5;
            cpu_write(16'hFF46, v);
            wait_idle(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL lat_timeout: got busy=%b expected 0", busy);
            end
            bad = log_bad(v);
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL lat_bus src=%h: got %0d bad ops expected 0", v, bad);
            end
            bad = oam_bad(v);
            checks++;
            if (bad !== 0 || done_cnt !== 1) begin
                errors++;
                $display("FAIL lat_oam src=%h: got %0d bad/%0d done expected 0/1",
                         v, bad, done_cnt);
            end
        end
    endtask

    task automatic test_restart();
        bit ok;
        int bad;
        fill_mem();
        clear_logs();
        lat_max = 2;
        cpu_write(16'hFF46, 8'hC0);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (wa_q.size() >= 37) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL restart_reach: got %0d writes expected 37", wa_q.size());
        end
        clear_logs();
        cpu_write(16'hFF46, 8'hD0);
        wait_idle(ok);
        checks++;
        if (!ok || rd_q.size() == 0 || rd_q[0] !== 16'hD000) begin
            errors++;
            $display("FAIL restart_first: got %h expected d000",
                     (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx);
        end
        bad = log_bad(8'hD0) + oam_bad(8'hD0);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL restart_data: got %0d bad expected 0", bad);
        end
        repeat (3) @(negedge clk);
        cpu_addr = 16'hFF46;
        #1;
        checks++;
        if (done_cnt !== 1 || cpu_rdata !== 8'hD0) begin
            errors++;
            $display("FAIL restart_done: got %0d/%h expected 1/d0", done_cnt, cpu_rdata);
        end
        cpu_addr = 16'h0000;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        fill_mem();
        clear_logs();
        lat_max = 3;
        cpu_write(16'hFF46, 8'hC0);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (m_req && m_we && m_addr == 16'hFE32) begin
                ok = 1'b1;
                break;
            end
        end
        resp_en   = 1'b0;
        force_ack = 1'b1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rmid_reach: got addr %h expected fe32", m_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cpu_addr = 16'hFF46;
        #1;
        checks++;
        if ({m_req, busy, oam_lock, cpu_rdata} !== 11'h000 || m_addr !== 16'h0) begin
            errors++;
            $display("FAIL rmid_clear: got %h/%h expected 000/0000",
                     {m_req, busy, oam_lock, cpu_rdata}, m_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if ({m_req, busy} !== 2'b00 || done_cnt !== 0 || wa_q.size() !== 50) begin
            errors++;
            $display("FAIL rmid_late_ack: got %b/%0d/%0d expected 00/0/50",
                     {m_req, busy}, done_cnt, wa_q.size());
        end
        force_ack = 1'b0;
        resp_en   = 1'b1;
        cpu_addr  = 16'h0000;
        clear_logs();
        lat_max = 0;
        cpu_write(16'hFF46, 8'h3C);
        wait_idle(ok);
        bad = log_bad(8'h3C);
        checks++;
        if (!ok || bad !== 0) begin
            errors++;
            $display("FAIL rmid_after: got %0d bad ops expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_echo();
        test_latency();
        test_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
